// File: rtl/pkt_rr_mux.sv
// pkt_rr_mux: N-port packet merger. Each port has a private store-and-forward
// FIFO; only complete packets become visible to the round-robin reader, which
// streams one packet at a time onto a single ready/valid output.
module pkt_rr_mux #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_W     = 134,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          data_in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
  output logic                          data_out_valid,
  output logic [DATA_W-1:0]             data_out,
  input  logic                          data_out_ready,
  output logic [NUM_PORTS-1:0]          drop_pulse
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(NUM_PORTS);
  localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WRITE = 2'd1, W_DROP = 2'd2} wst_e;
  typedef enum logic {A_ARB = 1'b0, A_SEND = 1'b1} ast_e;

  // Per-port storage and pointers (pointers carry one extra wrap bit)
  logic [DATA_W-1:0] mem_q [NUM_PORTS][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_PORTS];
  logic [PW-1:0] wr_ptr_d [NUM_PORTS];
  logic [PW-1:0] cm_ptr_q [NUM_PORTS];
  logic [PW-1:0] cm_ptr_d [NUM_PORTS];
  logic [PW-1:0] rd_ptr_q [NUM_PORTS];
  logic [PW-1:0] rd_ptr_d [NUM_PORTS];
  logic [PW-1:0] pkt_cnt_q [NUM_PORTS];
  logic [PW-1:0] pkt_cnt_d [NUM_PORTS];
  wst_e          wst_q [NUM_PORTS];
  wst_e          wst_d [NUM_PORTS];
  logic [AW-1:0] waddr_s [NUM_PORTS];
  logic [NUM_PORTS-1:0] we_s, drop_s, commit_s, rel_s;
  logic [NUM_PORTS-1:0] drop_q;

  // Read side state
  ast_e              ast_q, ast_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;

  // Scan helpers
  logic          found_s;
  logic [GW-1:0] sel_s;
  logic [GW-1:0] cand_s;

  // Write-side next state: head/single words restart from the commit point
  always_comb begin
    logic [1:0] tag_v;
    tag_v = 2'b00;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_ptr_d[p] = wr_ptr_q[p];
      cm_ptr_d[p] = cm_ptr_q[p];
      wst_d[p]    = wst_q[p];
      waddr_s[p]  = wr_ptr_q[p][AW-1:0];
      we_s[p]     = 1'b0;
      drop_s[p]   = 1'b0;
      commit_s[p] = 1'b0;
      tag_v       = data_in[p*DATA_W+DATA_W-2 +: 2];
      if (data_in_valid[p]) begin
        if (tag_v[0]) begin
          // head or single: any partial packet in progress is abandoned
          drop_s[p]   = (wst_q[p] == W_WRITE);
          wr_ptr_d[p] = cm_ptr_q[p];
          if ((cm_ptr_q[p] - rd_ptr_q[p]) < DEPTH_C) begin
            we_s[p]     = 1'b1;
            waddr_s[p]  = cm_ptr_q[p][AW-1:0];
            wr_ptr_d[p] = cm_ptr_q[p] + PW'(1);
            if (tag_v[1]) begin
              cm_ptr_d[p] = cm_ptr_q[p] + PW'(1);
              commit_s[p] = 1'b1;
              wst_d[p]    = W_IDLE;
            end else begin
              wst_d[p]    = W_WRITE;
            end
          end else begin
            drop_s[p] = 1'b1;
            wst_d[p]  = W_DROP;
          end
        end else if (wst_q[p] == W_WRITE) begin
          // body or tail of the packet being stored
          if ((wr_ptr_q[p] - rd_ptr_q[p]) < DEPTH_C) begin
            we_s[p]     = 1'b1;
            wr_ptr_d[p] = wr_ptr_q[p] + PW'(1);
            if (tag_v[1]) begin
              cm_ptr_d[p] = wr_ptr_q[p] + PW'(1);
              commit_s[p] = 1'b1;
              wst_d[p]    = W_IDLE;
            end else begin
              wst_d[p]    = W_WRITE;
            end
          end else begin
            // overflow: the tail itself already ends the dropped packet
            wr_ptr_d[p] = cm_ptr_q[p];
            drop_s[p]   = 1'b1;
            wst_d[p]    = tag_v[1] ? W_IDLE : W_DROP;
          end
        end else if ((wst_q[p] == W_DROP) && tag_v[1]) begin
          wst_d[p] = W_IDLE;
        end else begin
          wst_d[p] = wst_q[p];
        end
      end else begin
        wst_d[p] = wst_q[p];
      end
    end
  end

  // Committed-packet count: simultaneous commit and release cancel out
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      case ({commit_s[p], rel_s[p]})
        2'b10:   pkt_cnt_d[p] = pkt_cnt_q[p] + PW'(1);
        2'b01:   pkt_cnt_d[p] = pkt_cnt_q[p] - PW'(1);
        default: pkt_cnt_d[p] = pkt_cnt_q[p];
      endcase
    end
  end

  // Round-robin scan starting after the last granted port
  always_comb begin
    found_s = 1'b0;
    sel_s   = rr_q;
    cand_s  = rr_q;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_s = GW'((int'(rr_q) + i) % NUM_PORTS);
      if (!found_s && (pkt_cnt_q[cand_s] != PW'(0))) begin
        found_s = 1'b1;
        sel_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbiter/sender next state: one packet streamed at a time
  always_comb begin
    ast_d = ast_q;
    rr_d  = rr_q;
    gnt_d = gnt_q;
    dout_d = dout_q;
    vld_d = vld_q;
    rel_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_ptr_d[p] = rd_ptr_q[p];
    end
    case (ast_q)
      A_ARB: begin
        if (found_s) begin
          dout_d          = mem_q[sel_s][rd_ptr_q[sel_s][AW-1:0]];
          vld_d           = 1'b1;
          rd_ptr_d[sel_s] = rd_ptr_q[sel_s] + PW'(1);
          rr_d            = sel_s;
          gnt_d           = sel_s;
          ast_d           = A_SEND;
        end else begin
          vld_d = 1'b0;
        end
      end
      A_SEND: begin
        if (vld_q && data_out_ready) begin
          if (dout_q[DATA_W-1]) begin
            // tail or single accepted: packet leaves the FIFO
            rel_s[gnt_q] = 1'b1;
            vld_d        = 1'b0;
            ast_d        = A_ARB;
          end else begin
            dout_d          = mem_q[gnt_q][rd_ptr_q[gnt_q][AW-1:0]];
            rd_ptr_d[gnt_q] = rd_ptr_q[gnt_q] + PW'(1);
          end
        end else begin
          vld_d = vld_q;
        end
      end
      default: begin
        vld_d = 1'b0;
        ast_d = A_ARB;
      end
    endcase
  end

  // Packet storage, written one word per port per cycle
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (we_s[p]) begin
        mem_q[p][waddr_s[p]] <= data_in[p*DATA_W +: DATA_W];
      end
    end
  end

  // Control state registers; reset discards all buffered packets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p]  <= '0;
        cm_ptr_q[p]  <= '0;
        rd_ptr_q[p]  <= '0;
        pkt_cnt_q[p] <= '0;
        wst_q[p]     <= W_IDLE;
      end
      drop_q <= '0;
      ast_q  <= A_ARB;
      rr_q   <= GW'(NUM_PORTS - 1);
      gnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p]  <= wr_ptr_d[p];
        cm_ptr_q[p]  <= cm_ptr_d[p];
        rd_ptr_q[p]  <= rd_ptr_d[p];
        pkt_cnt_q[p] <= pkt_cnt_d[p];
        wst_q[p]     <= wst_d[p];
      end
      drop_q <= drop_s;
      ast_q  <= ast_d;
      rr_q   <= rr_d;
      gnt_q  <= gnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out_valid = vld_q;
  assign data_out       = dout_q;
  assign drop_pulse     = drop_q;

endmodule

// File: tb/tb_pkt_rr_mux.sv
// Directed bench for pkt_rr_mux (4 ports, 8-word FIFOs).
module tb_pkt_rr_mux;
  localparam int NP = 4;
  localparam int DW = 134;
  localparam int FD = 8;
  typedef logic [DW-1:0] w_t;

  logic             clk;
  logic             rst_n;
  logic [NP-1:0]    din_valid;
  logic [NP*DW-1:0] din;
  logic             dout_valid;
  logic [DW-1:0]    dout;
  logic             ready;
  logic [NP-1:0]    drop_pulse;

  int n_chk = 0;
  int n_err = 0;
  w_t got[$];
  int drops[NP];
  bit hold = 1'b0;
  w_t hold_data = '0;

  pkt_rr_mux #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .data_in_valid(din_valid), .data_in(din),
    .data_out_valid(dout_valid), .data_out(dout), .data_out_ready(ready),
    .drop_pulse(drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic w_t mkw(input logic [1:0] tag, input logic [7:0] id);
    return {tag, 4'hF, 120'd0, id};
  endfunction

  // inputs change just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input w_t w);
    din[p*DW +: DW] = w;
    din_valid[p]    = 1'b1;
  endtask

  task automatic step();
    tick();
    din_valid = '0;
  endtask

  task automatic put(input int p, input w_t w);
    set_port(p, w);
    step();
  endtask

  task automatic clear_obs();
    got.delete();
    for (int p = 0; p < NP; p++) drops[p] = 0;
  endtask

  task automatic cmp_got(input string tag, input w_t e[$]);
    chk($sformatf("%s_cnt", tag), w_t'(got.size()), w_t'(e.size()));
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got[i], e[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  // Output monitor: collects accepted words, counts drops, checks hold while stalled
  initial begin
    for (int p = 0; p < NP; p++) drops[p] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_vld", w_t'(dout_valid), w_t'(1));
          chk("hold_data", dout, hold_data);
        end
        if (dout_valid && ready) got.push_back(dout);
        for (int p = 0; p < NP; p++) if (drop_pulse[p]) drops[p]++;
        hold = dout_valid && !ready;
        hold_data = dout;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_t e[$];
    int k;
    rst_n = 1'b0; din_valid = '0; din = '0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", w_t'(dout_valid), w_t'(0));
    chk("rst_data", dout, w_t'(0));
    chk("rst_drop", w_t'(drop_pulse), w_t'(0));
    rst_n = 1'b1;
    tick();

    // 1: single 4-word packet on port 0, latency and content
    clear_obs();
    put(0, mkw(2'b01, 8'h10)); put(0, mkw(2'b00, 8'h11));
    put(0, mkw(2'b00, 8'h12)); put(0, mkw(2'b10, 8'h13));
    chk("t1_vld_commit", w_t'(dout_valid), w_t'(0));
    tick();
    chk("t1_vld_next", w_t'(dout_valid), w_t'(1));
    chk("t1_head", dout, mkw(2'b01, 8'h10));
    repeat (10) tick();
    e = '{mkw(2'b01, 8'h10), mkw(2'b00, 8'h11), mkw(2'b00, 8'h12), mkw(2'b10, 8'h13)};
    cmp_got("t1", e);
    chk("t1_drop0", w_t'(drops[0]), w_t'(0));

    // 2: ports 0 and 1 each three 2-word packets, alternating from port 0
    do_reset();
    clear_obs();
    for (int n = 0; n < 3; n++) begin
      set_port(0, mkw(2'b01, 8'(8'h20 + 2*n))); set_port(1, mkw(2'b01, 8'(8'h30 + 2*n))); step();
      set_port(0, mkw(2'b10, 8'(8'h21 + 2*n))); set_port(1, mkw(2'b10, 8'(8'h31 + 2*n))); step();
    end
    repeat (25) tick();
    e.delete();
    for (int n = 0; n < 3; n++) begin
      e.push_back(mkw(2'b01, 8'(8'h20 + 2*n))); e.push_back(mkw(2'b10, 8'(8'h21 + 2*n)));
      e.push_back(mkw(2'b01, 8'(8'h30 + 2*n))); e.push_back(mkw(2'b10, 8'(8'h31 + 2*n)));
    end
    cmp_got("t2", e);

    // 3: 10-word packet overflows port 1's 8-word FIFO, next packet intact
    clear_obs();
    put(1, mkw(2'b01, 8'h40));
    for (int n = 1; n <= 8; n++) put(1, mkw(2'b00, 8'(8'h40 + n)));
    put(1, mkw(2'b10, 8'h49));
    repeat (5) tick();
    chk("t3_nothing_out", w_t'(got.size()), w_t'(0));
    put(1, mkw(2'b01, 8'h50)); put(1, mkw(2'b10, 8'h51));
    repeat (8) tick();
    e = '{mkw(2'b01, 8'h50), mkw(2'b10, 8'h51)};
    cmp_got("t3", e);
    chk("t3_drop1", w_t'(drops[1]), w_t'(1));
    chk("t3_drop0", w_t'(drops[0]), w_t'(0));

    // 4: head, body, new head, tail on port 0 -> first packet dropped
    clear_obs();
    put(0, mkw(2'b01, 8'h60)); put(0, mkw(2'b00, 8'h61));
    put(0, mkw(2'b01, 8'h62)); put(0, mkw(2'b10, 8'h63));
    repeat (8) tick();
    e = '{mkw(2'b01, 8'h62), mkw(2'b10, 8'h63)};
    cmp_got("t4", e);
    chk("t4_drop0", w_t'(drops[0]), w_t'(1));

    // 5: single-word packets on all ports at once, ready toggling; last grant was port 0
    clear_obs();
    for (int p = 0; p < NP; p++) set_port(p, mkw(2'b11, 8'(8'h70 + p)));
    step();
    for (int n = 0; n < 24; n++) begin
      ready = ~ready;
      tick();
    end
    ready = 1'b1;
    repeat (6) tick();
    e = '{mkw(2'b11, 8'h71), mkw(2'b11, 8'h72), mkw(2'b11, 8'h73), mkw(2'b11, 8'h70)};
    cmp_got("t5", e);
    chk("t5_drops", w_t'(drops[0] + drops[1] + drops[2] + drops[3]), w_t'(0));

    // 6: reset while a packet is stalled in SEND
    clear_obs();
    ready = 1'b0;
    put(2, mkw(2'b01, 8'h80)); put(2, mkw(2'b00, 8'h81));
    put(2, mkw(2'b00, 8'h82)); put(2, mkw(2'b10, 8'h83));
    k = 0;
    while (!dout_valid && k < 10) begin tick(); k++; end
    chk("t6_stalled_vld", w_t'(dout_valid), w_t'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", w_t'(dout_valid), w_t'(0));
    chk("t6_rst_data", dout, w_t'(0));
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (10) tick();
    chk("t6_no_out", w_t'(got.size()), w_t'(0));
    chk("t6_idle_vld", w_t'(dout_valid), w_t'(0));
    put(3, mkw(2'b11, 8'h90));
    repeat (6) tick();
    e = '{mkw(2'b11, 8'h90)};
    cmp_got("t6", e);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
